sqrt_iter_unit: RTL and testbench

- Sequential square-root stage directly downstream of the -2ln(u0) logarithm unit in the AWGN Box-Muller datapath.
- Computes f = sqrt(e), where e = -2ln(u0) is an unsigned Q7.25 value.
- Produces an unsigned Q4.16 magnitude that is later multiplied by sin/cos(2*pi*u1).
- Digit-by-digit restoring algorithm, one result bit per clock, with valid/ready handshakes on both sides.

---
 rtl/sqrt_iter_unit.sv | 180 ++++++++++++++++++
 tb/tb_sqrt_iter_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_iter_unit.sv
// sqrt_iter_unit
//   Sequential square root for the AWGN Box-Muller datapath. It takes
//   e = -2ln(u0) as unsigned Q7.25 and returns f = floor(sqrt(e)) as
//   unsigned Q4.16. The restoring digit-by-digit method produces one
//   result bit per clock, and both sides use valid/ready handshakes.
//
//   Optional build macro: SQRT_SAT_EN
//     When defined, an all-ones operand (the log unit's infinity code)
//     skips the computation. The result is all ones with out_sat=1.
//     When undefined, out_sat is tied to 0 and all-ones computes normally.
//
//   Ports
//     clk        clock; all state changes on the rising edge
//     rst        synchronous, active-high reset
//     in_valid   in_data is valid
//     in_ready   unit is idle and can accept an operand
//     in_data    e, Q7.25 (IN_W bits)
//     out_valid  out_data / out_sat are valid
//     out_ready  consumer accepts the result
//     out_data   floor(sqrt(in_data << (2*OUT_W-IN_W-1))), Q4.16
//     out_sat    result was saturated (SQRT_SAT_EN only)
module sqrt_iter_unit #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat
);

    localparam int unsigned RW    = 2 * OUT_W;   // radicand width
    localparam int unsigned RMW   = OUT_W + 2;   // remainder width
    localparam int unsigned CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int          SHIFT = int'(RW) - int'(IN_W) - 1;

    generate
        if (RW < IN_W + 1) begin : g_bad_cfg
            $error("sqrt_iter_unit: 2*OUT_W must be >= IN_W+1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t state, state_nx;

    logic [RW-1:0]    rad;
    logic [RMW-1:0]   rem;
    logic [OUT_W-1:0] root;
    logic [CW-1:0]    cnt;

    logic [RW-1:0]    rad_init;
    logic [RMW+1:0]   rem_sh;
    logic [RMW+1:0]   trial;
    logic [RMW-1:0]   rem_nx;
    logic [OUT_W-1:0] root_nx;
    logic             accept;
    logic             last_step;

    // The MSB of R is zero, and the operand occupies the next IN_W bits.
    assign rad_init  = RW'(in_data) << SHIFT;
    assign accept    = in_valid && (state == ST_IDLE);
    assign last_step = (cnt == '0);

`ifdef SQRT_SAT_EN
    logic in_is_inf;
    logic sat_q;
    assign in_is_inf = &in_data;
    assign out_sat   = sat_q;
`else
    assign out_sat   = 1'b0;
`endif

    // FSM: next-state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef SQRT_SAT_EN
                    state_nx = in_is_inf ? ST_DONE : ST_CALC;
`else
                    state_nx = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (last_step) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // One restoring step. The next radicand pair is always the top two bits
    // of rad because rad shifts left by two each step. This replaces
    // indexing R[2*cnt+1:2*cnt]. The shifted remainder is kept two bits
    // wider for the compare. The true remainder always fits in RMW bits,
    // so narrowing it back loses nothing.
    always_comb begin
        rem_sh = {rem, rad[RW-1 -: 2]};
        trial  = {2'b00, root, 2'b01};
        if (rem_sh >= trial) begin
            rem_nx  = RMW'(rem_sh - trial);
            root_nx = {root[OUT_W-2:0], 1'b1};
        end else begin
            rem_nx  = RMW'(rem_sh);
            root_nx = {root[OUT_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rad      <= '0;
            rem      <= '0;
            root     <= '0;
            cnt      <= '0;
            out_data <= '0;
`ifdef SQRT_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rad  <= rad_init;
                        rem  <= '0;
                        root <= '0;
                        cnt  <= CW'(OUT_W - 1);
`ifdef SQRT_SAT_EN
                        sat_q <= in_is_inf;
                        if (in_is_inf) begin
                            out_data <= '1;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    rad  <= rad << 2;
                    rem  <= rem_nx;
                    root <= root_nx;
                    if (last_step) begin
                        out_data <= root_nx;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Self-checking bench for sqrt_iter_unit. A real-valued square root with
// integer correction serves as the reference.
module tb_sqrt_iter_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic        out_sat;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sqrt_iter_unit #(.IN_W(32), .OUT_W(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    function automatic longint unsigned ref_isqrt(input longint unsigned x);
        longint unsigned r;
        r = longint'($rtoi($sqrt(real'(x))));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic ref_model(input logic [31:0] d, output logic [19:0] q,
                             output logic s, output int lat);
`ifdef SQRT_SAT_EN
        if (d == 32'hFFFF_FFFF) begin
            q = 20'hFFFFF; s = 1'b1; lat = 0;
            return;
        end
`endif
        q   = 20'(ref_isqrt(longint'(d) << 7));
        s   = 1'b0;
        lat = 20;
    endtask

    // Stimulus only: present one operand, wait (bounded) for the result,
    // and complete the output handshake. Called at #1 after a rising edge.
    task automatic run_op(input logic [31:0] d, output logic [19:0] q,
                          output logic s, output int lat);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        q = out_data;
        s = out_sat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (out_data !== 20'h0) begin fails++; $display("FAIL reset_out_data: got %h expected 00000", out_data); end
        tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL reset_out_sat: got %b expected 0", out_sat); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] vec [4];
        logic [19:0] want [4];
        logic [19:0] q, eq;
        logic        s, es;
        int          lat, elat;
        vec[0] = 32'h0200_0000; want[0] = 20'h10000;
        vec[1] = 32'h0800_0000; want[1] = 20'h20000;
        vec[2] = 32'h0000_0000; want[2] = 20'h00000;
`ifdef SQRT_SAT_EN
        vec[3] = 32'hFFFF_FFFF; want[3] = 20'hFFFFF;
`else
        vec[3] = 32'hFFFF_FFFF; want[3] = 20'hB504F;
`endif
        for (int i = 0; i < 4; i++) begin
            ref_model(vec[i], eq, es, elat);
            run_op(vec[i], q, s, lat);
            tests++; if (q !== want[i]) begin fails++; $display("FAIL directed_data[%0d]: got %h expected %h", i, q, want[i]); end
            tests++; if (s !== es) begin fails++; $display("FAIL directed_sat[%0d]: got %b expected %b", i, s, es); end
            tests++; if (lat != elat) begin fails++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, elat); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [19:0] eq;
        logic        es;
        int          elat, lat;
        d = 32'h1357_9BDF;
        ref_model(d, eq, es, elat);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Keep offering garbage while busy; it must be ignored.
        lat = 0;
        while (!out_valid && lat < 100) begin
            in_data = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        tests++; if (lat != elat) begin fails++; $display("FAIL bp_latency: got %0d expected %0d", lat, elat); end
        for (int c = 0; c < 50; c++) begin
            in_data = $urandom;
            @(posedge clk); #1;
            tests++;
            if (out_data !== eq || out_sat !== es) begin
                fails++; $display("FAIL bp_hold_data[%0d]: got %h/%b expected %h/%b", c, out_data, out_sat, eq, es);
            end
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++; $display("FAIL bp_hold_hs[%0d]: got valid=%b ready=%b expected valid=1 ready=0", c, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        in_data   = 32'h0200_0000;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_next_accept: got ready=%b expected 0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++; if (lat != 20) begin fails++; $display("FAIL bp_next_latency: got %0d expected 20", lat); end
        tests++; if (out_data !== 20'h10000) begin fails++; $display("FAIL bp_next_data: got %h expected 10000", out_data); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        logic [19:0] q;
        logic        s;
        int          lat;
        run_op(32'h0800_0000, q, s, lat);   // leave a nonzero result behind
        in_data  = 32'h1234_5678;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 20'h0) begin
            fails++; $display("FAIL midcalc_reset: got ready=%b valid=%b data=%h expected 1/0/00000", in_ready, out_valid, out_data);
        end
        run_op(32'h0200_0000, q, s, lat);
        tests++; if (q !== 20'h10000) begin fails++; $display("FAIL midcalc_after_data: got %h expected 10000", q); end
        tests++; if (lat != 20) begin fails++; $display("FAIL midcalc_after_latency: got %0d expected 20", lat); end
    endtask

    task automatic test_random_sweep();
        logic [31:0] d;
        logic [19:0] q, eq;
        logic        s, es;
        int          lat, elat;
        int          sel;
        for (int n = 0; n < 2500; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       d = 32'h0;
                1:       d = 32'hFFFF_FFFF;
                2:       d = 32'($urandom_range(0, 255));
                default: d = $urandom;
            endcase
            ref_model(d, eq, es, elat);
            run_op(d, q, s, lat);
            tests++;
            if (q !== eq || s !== es) begin
                fails++; $display("FAIL sweep_data[%0d] in=%h: got %h/%b expected %h/%b", n, d, q, s, eq, es);
            end
            tests++;
            if (lat != elat) begin
                fails++; $display("FAIL sweep_latency[%0d] in=%h: got %0d expected %0d", n, d, lat, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_calc();
        test_random_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
